jtframe_romrq_arb: RTL and testbench

JTFRAME_ROMRQ_ARB -- requirements
Module: jtframe_romrq_arb

---
 rtl/jtframe_romrq_arb.sv | 158 +++++++++++++++
 tb/tb_jtframe_romrq_arb.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_romrq_arb.sv
// Purpose: three-slot, one-entry-per-slot ROM cache that arbitrates misses onto a single SDRAM request port.
// Latency: a miss raises sdram_req on the next edge; slotN_ok rises on the edge that samples data_rdy.
// Backpressure: sdram_req/sdram_addr are held until sdram_ack; only one transfer is in flight at a time.
// Ports: clk/rst (async, active-high); downloading, loop_rst control; slotN_cs/addr in, slotN_dout/ok out;
//        sdram_req/addr out, sdram_ack/data_rdy/data_read in; refresh_en out.
module jtframe_romrq_arb #(
    parameter logic [21:0] SLOT0_OFFSET = 22'h0,
    parameter logic [21:0] SLOT1_OFFSET = 22'h0,
    parameter logic [21:0] SLOT2_OFFSET = 22'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic        loop_rst,
    input  logic        slot0_cs,
    input  logic [21:0] slot0_addr,
    output logic [31:0] slot0_dout,
    output logic        slot0_ok,
    input  logic        slot1_cs,
    input  logic [21:0] slot1_addr,
    output logic [31:0] slot1_dout,
    output logic        slot1_ok,
    input  logic        slot2_cs,
    input  logic [21:0] slot2_addr,
    output logic [31:0] slot2_dout,
    output logic        slot2_ok,
    output logic        sdram_req,
    output logic [21:0] sdram_addr,
    input  logic        sdram_ack,
    input  logic        data_rdy,
    input  logic [31:0] data_read,
    output logic        refresh_en
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state_q;
    logic [1:0]        sel_q;
    logic [21:0]       lat_addr_q;
    logic              sdram_req_q;
    logic [21:0]       sdram_addr_q;
    logic [2:0]        valid_q;
    logic [2:0][21:0]  tag_q;
    logic [2:0][31:0]  data_q;

    logic [2:0]        cs;
    logic [2:0][21:0]  addr;
    logic [2:0]        ok;
    logic [2:0]        pending;

    logic [1:0]        pick_sel;
    logic [21:0]       pick_addr;
    logic [21:0]       pick_off;

    assign cs   = {slot2_cs, slot1_cs, slot0_cs};
    assign addr = {slot2_addr, slot1_addr, slot0_addr};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            ok[i]      = cs[i] & valid_q[i] & (tag_q[i] == addr[i]);
            pending[i] = cs[i] & ~ok[i];
        end
    end

    // Fixed priority: lowest index wins.
    always_comb begin
        pick_sel  = 2'd0;
        pick_addr = slot0_addr;
        pick_off  = SLOT0_OFFSET;
        if (pending[0]) begin
            pick_sel  = 2'd0;
            pick_addr = slot0_addr;
            pick_off  = SLOT0_OFFSET;
        end else if (pending[1]) begin
            pick_sel  = 2'd1;
            pick_addr = slot1_addr;
            pick_off  = SLOT1_OFFSET;
        end else if (pending[2]) begin
            pick_sel  = 2'd2;
            pick_addr = slot2_addr;
            pick_off  = SLOT2_OFFSET;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= 2'd0;
            lat_addr_q   <= 22'h0;
            sdram_req_q  <= 1'b0;
            sdram_addr_q <= 22'h0;
            valid_q      <= 3'b000;
            tag_q        <= '0;
            data_q       <= '0;
        end else if (loop_rst) begin
            // Abandon whatever is in flight; late data lands in IDLE and is ignored.
            state_q     <= IDLE;
            sdram_req_q <= 1'b0;
            valid_q     <= 3'b000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!downloading && (|pending)) begin
                        sel_q        <= pick_sel;
                        lat_addr_q   <= pick_addr;
                        sdram_addr_q <= pick_addr + pick_off;
                        sdram_req_q  <= 1'b1;
                        state_q      <= REQ;
                    end
                end
                REQ: begin
                    if (sdram_ack) begin
                        sdram_req_q <= 1'b0;
                        state_q     <= data_rdy ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (data_rdy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Fill uses the latched slot-relative address as tag, so a client that
            // moved away during the transfer will not see a false hit.
            if ((state_q == WAIT && data_rdy) || (state_q == REQ && sdram_ack && data_rdy)) begin
                for (int i = 0; i < 3; i++) begin
                    if (sel_q == 2'(i)) begin
                        data_q[i]  <= data_read;
                        tag_q[i]   <= lat_addr_q;
                        valid_q[i] <= 1'b1;
                    end
                end
            end

            // Overrides any fill above: data written during a download is never trusted.
            if (downloading) begin
                valid_q <= 3'b000;
            end
        end
    end

    assign slot0_ok   = ok[0];
    assign slot1_ok   = ok[1];
    assign slot2_ok   = ok[2];
    assign slot0_dout = data_q[0];
    assign slot1_dout = data_q[1];
    assign slot2_dout = data_q[2];
    assign sdram_req  = sdram_req_q;
    assign sdram_addr = sdram_addr_q;
    assign refresh_en = downloading | ((state_q == IDLE) & ~(|pending));

endmodule

// File: tb/tb_jtframe_romrq_arb.sv
// Purpose: directed self-checking bench for jtframe_romrq_arb.
// Latency: inputs driven 1 time unit after each rising edge; outputs sampled at that point.
// Backpressure: ack/data_rdy pulses are driven by the bench itself.
module tb_jtframe_romrq_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        downloading, loop_rst;
    logic        slot0_cs, slot1_cs, slot2_cs;
    logic [21:0] slot0_addr, slot1_addr, slot2_addr;
    logic [31:0] slot0_dout, slot1_dout, slot2_dout;
    logic        slot0_ok, slot1_ok, slot2_ok;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack, data_rdy;
    logic [31:0] data_read;
    logic        refresh_en;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jtframe_romrq_arb #(
        .SLOT0_OFFSET(22'h000010),
        .SLOT1_OFFSET(22'h008000),
        .SLOT2_OFFSET(22'h3FFFF0)
    ) dut (
        .clk(clk), .rst(rst), .downloading(downloading), .loop_rst(loop_rst),
        .slot0_cs(slot0_cs), .slot0_addr(slot0_addr), .slot0_dout(slot0_dout), .slot0_ok(slot0_ok),
        .slot1_cs(slot1_cs), .slot1_addr(slot1_addr), .slot1_dout(slot1_dout), .slot1_ok(slot1_ok),
        .slot2_cs(slot2_cs), .slot2_addr(slot2_addr), .slot2_dout(slot2_dout), .slot2_ok(slot2_ok),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
        .data_rdy(data_rdy), .data_read(data_read), .refresh_en(refresh_en)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; downloading = 1'b0; loop_rst = 1'b0;
        slot0_cs = 1'b0; slot1_cs = 1'b0; slot2_cs = 1'b0;
        slot0_addr = 22'h0; slot1_addr = 22'h0; slot2_addr = 22'h0;
        sdram_ack = 1'b0; data_rdy = 1'b0; data_read = 32'h0;
        #1;
        chk("rst_req", {31'b0, sdram_req}, 32'h0);
        chk("rst_addr", {10'b0, sdram_addr}, 32'h0);
        chk("rst_ok", {29'b0, slot2_ok, slot1_ok, slot0_ok}, 32'h0);
        chk("rst_refresh", {31'b0, refresh_en}, 32'h1);
        chk("rst_dout0", slot0_dout, 32'h0);
        chk("rst_dout2", slot2_dout, 32'h0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Basic miss and fill on slot 1 with offset
        slot1_cs = 1'b1; slot1_addr = 22'h000100;
        #1;
        chk("miss_ok0", {31'b0, slot1_ok}, 32'h0);
        chk("miss_refresh", {31'b0, refresh_en}, 32'h0);
        tick();
        chk("miss_req", {31'b0, sdram_req}, 32'h1);
        chk("miss_addr", {10'b0, sdram_addr}, 32'h008100);
        tick();
        chk("req_hold", {31'b0, sdram_req}, 32'h1);
        chk("req_hold_addr", {10'b0, sdram_addr}, 32'h008100);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        chk("ack_clr", {31'b0, sdram_req}, 32'h0);
        tick(); tick();
        data_rdy = 1'b1; data_read = 32'hDEADBEEF;
        tick();
        data_rdy = 1'b0;
        chk("fill_ok", {31'b0, slot1_ok}, 32'h1);
        chk("fill_dout", slot1_dout, 32'hDEADBEEF);
        chk("fill_refresh", {31'b0, refresh_en}, 32'h1);

        // Hit, then a new address misses
        tick();
        chk("hit_req", {31'b0, sdram_req}, 32'h0);
        chk("hit_ok", {31'b0, slot1_ok}, 32'h1);
        slot1_addr = 22'h000101;
        #1;
        chk("newaddr_ok", {31'b0, slot1_ok}, 32'h0);
        tick();
        chk("newaddr_req", {31'b0, sdram_req}, 32'h1);
        chk("newaddr_addr", {10'b0, sdram_addr}, 32'h008101);
        // ack and data in the same cycle
        sdram_ack = 1'b1; data_rdy = 1'b1; data_read = 32'hCAFEF00D;
        tick();
        sdram_ack = 1'b0; data_rdy = 1'b0;
        chk("same_req", {31'b0, sdram_req}, 32'h0);
        chk("same_ok", {31'b0, slot1_ok}, 32'h1);
        chk("same_dout", slot1_dout, 32'hCAFEF00D);
        tick();
        chk("same_nohang", {31'b0, sdram_req}, 32'h0);

        // Stray data_rdy in IDLE is ignored
        slot1_cs = 1'b0;
        data_rdy = 1'b1; data_read = 32'h12345678;
        tick();
        data_rdy = 1'b0; slot1_cs = 1'b1;
        #1;
        chk("stray_ok", {31'b0, slot1_ok}, 32'h1);
        chk("stray_dout", slot1_dout, 32'hCAFEF00D);
        slot1_cs = 1'b0;

        // Priority: slot0 before slot2; slot2 offset wraps
        slot0_cs = 1'b1; slot0_addr = 22'h000005;
        slot2_cs = 1'b1; slot2_addr = 22'h000020;
        tick();
        chk("prio_addr0", {10'b0, sdram_addr}, 32'h000015);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        data_rdy = 1'b1; data_read = 32'h00000A0A;
        tick();
        data_rdy = 1'b0;
        chk("prio_ok0", {31'b0, slot0_ok}, 32'h1);
        chk("prio_ok2", {31'b0, slot2_ok}, 32'h0);
        chk("prio_idle_req", {31'b0, sdram_req}, 32'h0);
        tick();
        chk("prio_req2", {31'b0, sdram_req}, 32'h1);
        chk("prio_wrap_addr", {10'b0, sdram_addr}, 32'h000010);
        // Client moves during transfer: stored under latched tag
        slot2_addr = 22'h000021;
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        data_rdy = 1'b1; data_read = 32'h00002222;
        tick();
        data_rdy = 1'b0;
        chk("move_noflse_ok", {31'b0, slot2_ok}, 32'h0);
        slot2_addr = 22'h000020;
        #1;
        chk("move_tag_ok", {31'b0, slot2_ok}, 32'h1);
        chk("move_dout", slot2_dout, 32'h00002222);
        tick();
        chk("move_noreq", {31'b0, sdram_req}, 32'h0);

        // loop_rst during WAIT
        slot0_addr = 22'h000006;
        tick();
        chk("lr_addr", {10'b0, sdram_addr}, 32'h000016);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        loop_rst = 1'b1;
        tick();
        loop_rst = 1'b0;
        chk("lr_req", {31'b0, sdram_req}, 32'h0);
        chk("lr_ok", {29'b0, slot2_ok, slot1_ok, slot0_ok}, 32'h0);
        slot0_cs = 1'b0; slot2_cs = 1'b0;
        data_rdy = 1'b1; data_read = 32'h99999999;
        tick();
        data_rdy = 1'b0;
        chk("lr_late_req", {31'b0, sdram_req}, 32'h0);
        chk("lr_dout0", slot0_dout, 32'h00000A0A);
        slot2_cs = 1'b1;
        #1;
        chk("lr_ok2", {31'b0, slot2_ok}, 32'h0);
        chk("lr_dout2", slot2_dout, 32'h00002222);

        // Downloading blocks requests; resume in slot order
        downloading = 1'b1;
        slot0_cs = 1'b1; slot1_cs = 1'b1; slot1_addr = 22'h000100;
        tick(); tick();
        chk("dl_req", {31'b0, sdram_req}, 32'h0);
        chk("dl_refresh", {31'b0, refresh_en}, 32'h1);
        chk("dl_ok", {29'b0, slot2_ok, slot1_ok, slot0_ok}, 32'h0);
        downloading = 1'b0;
        #1;
        chk("dl_off_refresh", {31'b0, refresh_en}, 32'h0);
        tick();
        chk("res_addr0", {10'b0, sdram_addr}, 32'h000016);
        sdram_ack = 1'b1; data_rdy = 1'b1; data_read = 32'h00000006;
        tick();
        sdram_ack = 1'b0; data_rdy = 1'b0;
        chk("res_ok0", {31'b0, slot0_ok}, 32'h1);
        tick();
        chk("res_addr1", {10'b0, sdram_addr}, 32'h008100);
        sdram_ack = 1'b1; data_rdy = 1'b1; data_read = 32'h00000111;
        tick();
        sdram_ack = 1'b0; data_rdy = 1'b0;
        chk("res_ok1", {31'b0, slot1_ok}, 32'h1);
        tick();
        chk("res_addr2", {10'b0, sdram_addr}, 32'h000010);
        sdram_ack = 1'b1; data_rdy = 1'b1; data_read = 32'h00000222;
        tick();
        sdram_ack = 1'b0; data_rdy = 1'b0;
        chk("res_ok2", {31'b0, slot2_ok}, 32'h1);
        chk("res_dout2", slot2_dout, 32'h00000222);
        chk("res_refresh", {31'b0, refresh_en}, 32'h1);

        // In-flight transfer finishing while downloading does not set valid
        slot0_addr = 22'h000007;
        tick();
        chk("dlf_addr", {10'b0, sdram_addr}, 32'h000017);
        downloading = 1'b1;
        sdram_ack = 1'b1; data_rdy = 1'b1; data_read = 32'h00000777;
        tick();
        sdram_ack = 1'b0; data_rdy = 1'b0; downloading = 1'b0;
        #1;
        chk("dlf_ok0", {31'b0, slot0_ok}, 32'h0);
        chk("dlf_ok1", {31'b0, slot1_ok}, 32'h0);

        // Reset mid-transfer
        tick();
        chk("rmid_req", {31'b0, sdram_req}, 32'h1);
        rst = 1'b1;
        #1;
        chk("rmid_req_clr", {31'b0, sdram_req}, 32'h0);
        slot0_cs = 1'b0; slot1_cs = 1'b0; slot2_cs = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("rmid_after", {31'b0, sdram_req}, 32'h0);
        chk("rmid_addr", {10'b0, sdram_addr}, 32'h0);
        chk("rmid_refresh", {31'b0, refresh_en}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
